piano_key_decoder: RTL and testbench
====================================

// Module: piano_key_decoder
// PURPOSE
//  Front end of the electric piano, directly upstream of the tone generator.
//  Synchronises and debounces the raw key switches (7 note keys, octave up/down).
//  Selects one note by priority and tracks a saturating octave register.
//  Presents note/octave/gate in the encoding the tone generator consumes: note 0..6 = C..B, octave 0..5.
// PARAMETERS
//  NUM_KEYS          7      note keys; key i maps to note i (0=C .. 6=B)
//  SAMPLE_DIV        50000  clk cycles per debounce sample tick (>=2)
//  DEBOUNCE_SAMPLES  4      consecutive equal samples needed to accept a level change (>=1)
//  OCT_MIN           0      lowest octave
//  OCT_MAX           5      highest octave
//  OCT_RESET         2      octave after reset (OCT_MIN..OCT_MAX)
// PORTS
//  clk       in   1         system clock; all state on rising edge
//  rst_n     in   1         asynchronous, active-low reset
//  keys      in   NUM_KEYS  raw note switches, 1 = pressed, asynchronous to clk
//  oct_up    in   1         raw octave-up button, 1 = pressed
//  oct_dn    in   1         raw octave-down button, 1 = pressed
//  note      out  4         selected note index 0..6; holds last value when gate=0
//  octave    out  3         current octave OCT_MIN..OCT_MAX
//  gate      out  1         1 while at least one debounced note key is pressed
//  new_note  out  1         1-cycle pulse when gate rises or note changes while gated
// BEHAVIOUR
//  - Reset (async assert, sync release): all debounced levels 0, tick counter 0,
//    note=0, octave=OCT_RESET, gate=0, new_note=0.
//  - Every raw input passes a 2-FF synchroniser before use.
//  - Tick counter counts 0..SAMPLE_DIV-1 and wraps; tick=1 for one cycle at the wrap.
//  - Debounce, per input, evaluated only on tick:
//    - sample == debounced level -> stability count cleared;
//    - else count increments; on reaching DEBOUNCE_SAMPLES the level flips and the count clears.
//    - Glitches shorter than DEBOUNCE_SAMPLES ticks never reach the outputs.
//  - Note select, combinational on the debounced keys:
//    - lowest-index pressed key wins (C has highest priority);
//    - none pressed -> candidate invalid.
//  - Output register, 1 cycle after a debounced change:
//    - gate <= any key pressed;
//    - note <= candidate when valid, else note holds;
//    - new_note <= (valid && !gate) || (valid && candidate != note).
//  - Release of all keys: gate falls, no new_note, note unchanged.
//  - Octave: acts on a debounced rising edge of oct_up / oct_dn.
//    - up: +1, saturating at OCT_MAX. dn: -1, saturating at OCT_MIN.
//    - Both edges in the same cycle -> no change.
//    - Octave changes never pulse new_note.
//  - Latency, raw edge to output: 2 cycles (sync) + DEBOUNCE_SAMPLES ticks (plus partial tick) + 1 cycle.
//  - Reset mid-debounce discards partial counts; held keys are re-accepted after full debounce.
// STRUCTURE
//  - Package piano_pkg: NOTE_C..NOTE_B (0..6), NUM_NOTES=7, NOTE_W=4, OCT_W=3 and default octave limits.
//    The tone generator uses the same package.
//  - Sub-module key_debounce: one input bit; synchroniser, stability counter, debounced level, rise strobe.
//    Shared tick input; instantiated NUM_KEYS+2 times.
//  - Top level holds the tick counter, priority encoder, output register and octave register.
// TESTING (bench uses SAMPLE_DIV=4, DEBOUNCE_SAMPLES=3)
//  - Reset: rst_n=0 mid-run -> note=0, octave=2, gate=0, new_note=0 immediately.
//  - Press keys[4] (G) steadily -> gate=1 and note=4 within 2+12+4+1 cycles; new_note high exactly 1 cycle.
//  - Toggle keys[2] for 2 ticks then release -> gate, note and new_note unchanged.
//  - Hold keys[4], then add keys[1] -> note 4->1 with one new_note pulse.
//    Release keys[1] -> note=4 with a pulse. Release all -> gate=0, note=4, no pulse.
//  - Six clean oct_up presses from reset -> octave 3,4,5,5,5,5.
//    Then eight oct_dn presses -> octave reaches 0 and stays 0.
//  - oct_up and oct_dn pressed in the same cycle -> octave unchanged; each alone afterwards -> +/-1.

Source files
------------

// File: rtl/piano_key_decoder_pkg.sv
// Shared encodings between the key decoder and the tone generator:
// note indices, output widths and the default octave range.
package piano_pkg;

  localparam int NUM_NOTES = 7;
  localparam int NOTE_W    = 4;
  localparam int OCT_W     = 3;

  localparam int OCT_MIN_DEF   = 0;
  localparam int OCT_MAX_DEF   = 5;
  localparam int OCT_RESET_DEF = 2;

  typedef enum logic [NOTE_W-1:0] {
    NOTE_C = 4'd0,
    NOTE_D = 4'd1,
    NOTE_E = 4'd2,
    NOTE_F = 4'd3,
    NOTE_G = 4'd4,
    NOTE_A = 4'd5,
    NOTE_B = 4'd6
  } note_e;

  // Saturating octave step; simultaneous up and down cancel out.
  function automatic logic [OCT_W-1:0] oct_step(
    input logic [OCT_W-1:0] cur,
    input logic             up,
    input logic             dn,
    input int               lo,
    input int               hi
  );
    logic [OCT_W-1:0] res;
    res = cur;
    if (up && !dn && (cur < OCT_W'(hi)))
      res = cur + 1'b1;
    else if (dn && !up && (cur > OCT_W'(lo)))
      res = cur - 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/piano_key_decoder_if.sv
// Key-switch inputs and note/octave/gate outputs of the piano front end.
// master = switch side / consumer, slave = decoder.
interface piano_key_decoder_if #(
  parameter int NUM_KEYS = 7
);
  import piano_pkg::*;

  logic [NUM_KEYS-1:0] keys;
  logic                oct_up;
  logic                oct_dn;
  logic [NOTE_W-1:0]   note;
  logic [OCT_W-1:0]    octave;
  logic                gate;
  logic                new_note;

  modport master (
    output keys, oct_up, oct_dn,
    input  note, octave, gate, new_note
  );

  modport slave (
    input  keys, oct_up, oct_dn,
    output note, octave, gate, new_note
  );

endinterface

// File: rtl/piano_key_decoder_key_debounce.sv
// One raw switch: 2-FF synchroniser, tick-sampled stability counter,
// debounced level and a one-cycle strobe when the level rises.
module key_debounce #(
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_SAMPLES + 1);

  logic          sync1_reg, sync2_reg;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          level_reg, level_next;
  logic          rise_reg, rise_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      cnt_reg   <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      cnt_reg   <= cnt_next;
      level_reg <= level_next;
      rise_reg  <= rise_next;
    end
  end

  // Any sample agreeing with the current level restarts the stability run.
  always_comb begin
    cnt_next   = cnt_reg;
    level_next = level_reg;
    rise_next  = 1'b0;
    if (tick) begin
      if (sync2_reg == level_reg) begin
        cnt_next = '0;
      end else if (cnt_reg + 1'b1 == CW'(DEBOUNCE_SAMPLES)) begin
        cnt_next   = '0;
        level_next = ~level_reg;
        rise_next  = ~level_reg;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;

endmodule

// File: rtl/piano_key_decoder.sv
// Piano key front end: debounces note and octave buttons, picks the
// highest-priority note and keeps a saturating octave register.
module piano_key_decoder
  import piano_pkg::*;
#(
  parameter int NUM_KEYS         = NUM_NOTES,
  parameter int SAMPLE_DIV       = 50000,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int OCT_MIN          = OCT_MIN_DEF,
  parameter int OCT_MAX          = OCT_MAX_DEF,
  parameter int OCT_RESET        = OCT_RESET_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  piano_key_decoder_if.slave    bus
);

  localparam int NUM_IN = NUM_KEYS + 2;
  localparam int TW     = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [TW-1:0]      tick_cnt_reg;
  logic               tick;
  logic [NUM_IN-1:0]  raw_vec;
  logic [NUM_IN-1:0]  level_vec;
  logic [NUM_IN-1:0]  rise_vec;
  logic [NUM_KEYS-1:0] key_level;
  logic               up_rise, dn_rise;
  logic               unused_bits;

  logic [NOTE_W-1:0]  cand;
  logic               cand_valid;
  logic [NOTE_W-1:0]  note_reg, note_next;
  logic               gate_reg, gate_next;
  logic               new_note_reg, new_note_next;
  logic [OCT_W-1:0]   octave_reg, octave_next;

  assign tick = (tick_cnt_reg == TW'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tick_cnt_reg <= '0;
    else if (tick)
      tick_cnt_reg <= '0;
    else
      tick_cnt_reg <= tick_cnt_reg + 1'b1;
  end

  // Octave buttons ride along as the two top debouncer lanes.
  assign raw_vec = {bus.oct_dn, bus.oct_up, bus.keys};

  generate
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_db
      key_debounce #(
        .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
      ) u_db (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick),
        .raw  (raw_vec[gi]),
        .level(level_vec[gi]),
        .rise (rise_vec[gi])
      );
    end
  endgenerate

  assign key_level   = level_vec[NUM_KEYS-1:0];
  assign up_rise     = rise_vec[NUM_KEYS];
  assign dn_rise     = rise_vec[NUM_KEYS+1];
  assign unused_bits = ^{level_vec[NUM_IN-1:NUM_KEYS], rise_vec[NUM_KEYS-1:0]};

  // Scan high to low so the lowest pressed index is the last to write.
  always_comb begin
    cand       = NOTE_C;
    cand_valid = 1'b0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (key_level[i]) begin
        cand       = NOTE_W'(i);
        cand_valid = 1'b1;
      end
    end
  end

  always_comb begin
    gate_next     = cand_valid;
    note_next     = cand_valid ? cand : note_reg;
    new_note_next = cand_valid && (!gate_reg || (cand != note_reg));
    octave_next   = oct_step(octave_reg, up_rise, dn_rise, OCT_MIN, OCT_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      note_reg     <= NOTE_C;
      gate_reg     <= 1'b0;
      new_note_reg <= 1'b0;
      octave_reg   <= OCT_W'(OCT_RESET);
    end else begin
      note_reg     <= note_next;
      gate_reg     <= gate_next;
      new_note_reg <= new_note_next;
      octave_reg   <= octave_next;
    end
  end

  assign bus.note     = note_reg;
  assign bus.gate     = gate_reg;
  assign bus.new_note = new_note_reg;
  assign bus.octave   = octave_reg;

endmodule

// File: tb/tb_piano_key_decoder.sv
// Directed bench for piano_key_decoder with a short tick (SAMPLE_DIV=4)
// and three-sample debounce.
module tb_piano_key_decoder;
  import piano_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  piano_key_decoder_if #(.NUM_KEYS(7)) bus ();

  piano_key_decoder #(
    .NUM_KEYS        (7),
    .SAMPLE_DIV      (4),
    .DEBOUNCE_SAMPLES(3),
    .OCT_MIN         (0),
    .OCT_MAX         (5),
    .OCT_RESET       (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for a new_note pulse, then check note, gate and pulse width.
  task automatic wait_pulse(input string tag, input int exp_note, input int max_cyc);
    int k = 0;
    bit seen = 1'b0;
    while (k < max_cyc && !seen) begin
      step();
      k++;
      if (bus.new_note === 1'b1) seen = 1'b1;
    end
    check({tag, " pulse seen"}, 32'(seen), 1);
    check({tag, " note"}, 32'(bus.note), exp_note);
    check({tag, " gate"}, 32'(bus.gate), 1);
    step();
    check({tag, " pulse width"}, 32'(bus.new_note), 0);
    $display("step %s: note=%0d gate=%0d after %0d cycles", tag, bus.note, bus.gate, k);
  endtask

  task automatic wait_release(input string tag, input int exp_note, input int max_cyc);
    int k = 0;
    int pulses = 0;
    while (k < max_cyc && bus.gate !== 1'b0) begin
      step();
      k++;
      if (bus.new_note === 1'b1) pulses++;
    end
    check({tag, " gate low"}, 32'(bus.gate), 0);
    check({tag, " no pulse"}, 32'(pulses), 0);
    check({tag, " note held"}, 32'(bus.note), exp_note);
    $display("step %s: gate=%0d note=%0d after %0d cycles", tag, bus.gate, bus.note, k);
  endtask

  task automatic press_oct(input string tag, input logic up, input logic dn, input int exp_oct);
    int pulses = 0;
    bus.oct_up = up;
    bus.oct_dn = dn;
    repeat (20) begin
      step();
      if (bus.new_note === 1'b1) pulses++;
    end
    bus.oct_up = 1'b0;
    bus.oct_dn = 1'b0;
    repeat (20) begin
      step();
      if (bus.new_note === 1'b1) pulses++;
    end
    check({tag, " octave"}, 32'(bus.octave), exp_oct);
    check({tag, " no new_note"}, 32'(pulses), 0);
    $display("step %s: up=%0b dn=%0b octave=%0d", tag, up, dn, bus.octave);
  endtask

  initial begin
    int glitch_bad;
    int up_exp [6] = '{3, 4, 5, 5, 5, 5};
    int dn_exp [8] = '{4, 3, 2, 1, 0, 0, 0, 0};

    bus.keys   = '0;
    bus.oct_up = 1'b0;
    bus.oct_dn = 1'b0;

    repeat (3) step();
    check("reset note", 32'(bus.note), 0);
    check("reset octave", 32'(bus.octave), 2);
    check("reset gate", 32'(bus.gate), 0);
    check("reset new_note", 32'(bus.new_note), 0);
    $display("step reset: note=%0d octave=%0d gate=%0d", bus.note, bus.octave, bus.gate);
    rst_n = 1'b1;

    bus.keys[4] = 1'b1;
    wait_pulse("press G", 4, 19);

    // Two-tick glitch on E while G is held must not disturb the outputs.
    glitch_bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 0) bus.keys[2] = 1'b1;
      if (i == 8) bus.keys[2] = 1'b0;
      step();
      if (bus.note !== 4'd4 || bus.gate !== 1'b1 || bus.new_note !== 1'b0) glitch_bad++;
    end
    check("glitch E bad cycles", 32'(glitch_bad), 0);
    check("glitch E note", 32'(bus.note), 4);
    $display("step glitch E: note=%0d gate=%0d bad=%0d", bus.note, bus.gate, glitch_bad);

    bus.keys[1] = 1'b1;
    wait_pulse("add D", 1, 25);
    bus.keys[1] = 1'b0;
    wait_pulse("drop D", 4, 25);
    bus.keys[4] = 1'b0;
    wait_release("release all", 4, 25);

    press_oct("pre-reset up", 1'b1, 1'b0, 3);
    bus.keys[4] = 1'b1;
    wait_pulse("G before reset", 4, 25);

    #2;
    rst_n = 1'b0;
    #1;
    check("midrun reset note", 32'(bus.note), 0);
    check("midrun reset octave", 32'(bus.octave), 2);
    check("midrun reset gate", 32'(bus.gate), 0);
    check("midrun reset new_note", 32'(bus.new_note), 0);
    $display("step midrun reset: note=%0d octave=%0d gate=%0d", bus.note, bus.octave, bus.gate);
    repeat (2) step();
    rst_n = 1'b1;
    wait_pulse("reaccept G", 4, 25);
    check("reaccept octave", 32'(bus.octave), 2);
    bus.keys[4] = 1'b0;
    wait_release("release G", 4, 25);

    for (int i = 0; i < 6; i++) press_oct($sformatf("up %0d", i), 1'b1, 1'b0, up_exp[i]);
    for (int i = 0; i < 8; i++) press_oct($sformatf("dn %0d", i), 1'b0, 1'b1, dn_exp[i]);

    press_oct("up to 1", 1'b1, 1'b0, 1);
    press_oct("both", 1'b1, 1'b1, 1);
    press_oct("up after both", 1'b1, 1'b0, 2);
    press_oct("dn after both", 1'b0, 1'b1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
